// File: rtl/specan_pkg.sv
// Shared types and helpers for the spectrum-analyser front end.
package specan_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } packer_state_t;

  // Offset-binary to two's complement: flip the MSB of a width-bit sample.
  function automatic logic [31:0] offset_to_twos(input logic [31:0] sample,
                                                 input int unsigned width);
    return sample ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// One-entry AXI-Stream output register: data/last/valid held until the sink takes them.
module axis_hold_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last,
  output logic         can_load
);

  // Loading is legal when the entry is empty or leaves this cycle; valid never looks at ready.
  assign can_load = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_packer.sv
// Frames a free-running real sample stream into fixed-length complex AXI-Stream bursts.
module fft_frame_packer
  import specan_pkg::*;
#(
  parameter int DATA_WIDTH    = 24,
  parameter int N_FFT         = 9,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_WIDTH/2-1:0] data_in_data,
  input  logic                    data_in_valid,
  input  logic                    data_in_last,
  output logic                    data_in_ready,
  output logic [DATA_WIDTH-1:0]   data_out_data,
  output logic                    data_out_valid,
  output logic                    data_out_last,
  input  logic                    data_out_ready,
  output logic                    overflow,
  output logic [31:0]             dropped_count,
  output packer_state_t           state_dbg
);

  // Handshake rule for both streams: a beat transfers on a rising clk edge where
  // valid and ready are both high; the producer holds valid/data/last until then.

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [N_FFT-1:0] LAST_IDX = {N_FFT{1'b1}};

  packer_state_t        state, state_d;
  logic [N_FFT-1:0]     load_idx, idx_d;
  logic                 load, load_last, drop, can_load;
  logic [31:0]          conv_full;
  logic [HALF-1:0]      conv;
  logic                 unused_bits;

  // The source is never stalled; ready only drops while reset is held.
  assign data_in_ready = !reset;
  assign state_dbg     = state;

  assign conv_full = OFFSET_BINARY ? offset_to_twos(32'(data_in_data), HALF)
                                   : 32'(data_in_data);
  assign conv        = conv_full[HALF-1:0];
  assign unused_bits = data_in_last ^ (^conv_full);

  axis_hold_reg #(.W(DATA_WIDTH)) u_hold (
    .clk       (clk),
    .rst       (reset),
    .load      (load),
    .load_data ({{HALF{1'b0}}, conv}),
    .load_last (load_last),
    .ready     (data_out_ready),
    .valid     (data_out_valid),
    .data      (data_out_data),
    .last      (data_out_last),
    .can_load  (can_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= WAIT;
      load_idx      <= '0;
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else begin
      state    <= state_d;
      load_idx <= idx_d;
      overflow <= drop;
      if (drop && (dropped_count != 32'hFFFF_FFFF))
        dropped_count <= dropped_count + 32'd1;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = load_idx;
    load      = 1'b0;
    load_last = 1'b0;
    drop      = 1'b0;
    case (state)
      WAIT: begin
        // A frame may only open when the FFT is ready to take its first beat.
        if (data_in_valid && enable && data_out_ready) begin
          load    = 1'b1;
          idx_d   = N_FFT'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (data_in_valid) begin
          if (can_load) begin
            load      = 1'b1;
            load_last = (load_idx == LAST_IDX);
            if (load_last) begin
              idx_d   = '0;
              state_d = DRAIN;
            end else begin
              idx_d = load_idx + 1'b1;
            end
          end else begin
            drop = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (data_out_valid && data_out_ready && data_out_last)
          state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

endmodule
